// File: rtl/uart_arb_pkg.sv
// Shared constants and FSM encoding for the uart_tx request arbiter.
package uart_arb_pkg;

   localparam int BYTE_W          = 8;
   localparam int TIMEOUT_CYC_DEF = 20000;

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      LAUNCH    = 2'd1,
      WAIT_DONE = 2'd2
   } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first set valid bit strictly after index 'last', wrapping.
module rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         valid,
   input  logic [$clog2(N)-1:0] last,
   output logic [N-1:0]         grant,
   output logic [$clog2(N)-1:0] idx,
   output logic                 hit
);

   localparam int IW = $clog2(N);

   logic [N-1:0] rot;
   int           off;
   int           sum;

   always_comb begin
      // Doubling the vector turns the wrap-around rotate into a plain shift.
      rot = N'({valid, valid} >> (int'(last) + 1));
      off = 0;
      hit = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (rot[k]) begin
            off = k;
            hit = 1'b1;
         end
      end
      sum = int'(last) + 1 + off;
      if (sum >= N) sum = sum - N;
      idx   = IW'(sum);
      grant = hit ? (N'(1) << idx) : '0;
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one uart_tx between NUM_REQ byte producers: round-robin grant,
// launch, completion wait with a hung-transmitter timeout.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
   input  logic                       clk,
   input  logic                       sw_reset,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [BYTE_W*NUM_REQ-1:0]  req_data,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic                       tx_busy,
   input  logic                       tx_done,
   output logic                       tx_start,
   output logic [BYTE_W-1:0]          tx_data,
   output logic [$clog2(NUM_REQ)-1:0] grant_id,
   output logic                       arb_busy,
   output logic                       err_timeout
);

   localparam int            IW      = $clog2(NUM_REQ);
   localparam int            CW      = $clog2(TIMEOUT_CYC);
   localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYC - 1);

   arb_state_t         state;
   arb_state_t         state_nxt;
   logic [IW-1:0]      last_grant;
   logic [NUM_REQ-1:0] pick_grant;
   logic [IW-1:0]      pick_idx;
   logic               pick_hit;
   logic [CW-1:0]      cnt;
   logic               timeout_hit;

   rr_pick #(.N(NUM_REQ)) u_pick (
      .valid (req_valid),
      .last  (last_grant),
      .grant (pick_grant),
      .idx   (pick_idx),
      .hit   (pick_hit)
   );

   always_ff @(posedge clk or posedge sw_reset) begin
      if (sw_reset) state <= IDLE;
      else          state <= state_nxt;
   end

   // req_ready is combinational in IDLE, so it is masked while reset is held.
   always_comb begin
      state_nxt   = state;
      req_ready   = '0;
      tx_start    = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (pick_hit && !sw_reset) begin
               req_ready = pick_grant;
               state_nxt = LAUNCH;
            end
         end
         LAUNCH: begin
            if (!tx_busy) begin
               tx_start  = 1'b1;
               state_nxt = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (tx_done) begin
               state_nxt = IDLE;
            end else if (cnt == CNT_MAX) begin
               timeout_hit = 1'b1;
               state_nxt   = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign arb_busy = (state != IDLE);

   always_ff @(posedge clk or posedge sw_reset) begin
      if (sw_reset) begin
         tx_data     <= '0;
         grant_id    <= '0;
         last_grant  <= IW'(NUM_REQ - 1);
         cnt         <= '0;
         err_timeout <= 1'b0;
      end else begin
         if (|req_ready) begin
            tx_data    <= req_data[BYTE_W*pick_idx +: BYTE_W];
            grant_id   <= pick_idx;
            last_grant <= pick_idx;
         end
         // Saturates at CNT_MAX; only tx_start restarts it.
         if (tx_start) begin
            cnt <= '0;
         end else if (state == WAIT_DONE && cnt != CNT_MAX) begin
            cnt <= cnt + CW'(1);
         end
         if (timeout_hit) err_timeout <= 1'b1;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a byte scoreboard checked at each tx_start.
module tb_uart_tx_arbiter;

   localparam int N = 4;
   localparam int T = 64;

   logic          clk = 1'b0;
   logic          sw_reset;
   logic [N-1:0]  req_valid;
   logic [8*N-1:0] req_data;
   logic [N-1:0]  req_ready;
   logic          tx_busy;
   logic          tx_done;
   logic          tx_start;
   logic [7:0]    tx_data;
   logic [1:0]    grant_id;
   logic          arb_busy;
   logic          err_timeout;

   int unsigned   n_cmp = 0;
   int unsigned   n_bad = 0;
   logic [7:0]    exp_q[$];

   uart_tx_arbiter #(.NUM_REQ(N), .TIMEOUT_CYC(T)) dut (
      .clk         (clk),
      .sw_reset    (sw_reset),
      .req_valid   (req_valid),
      .req_data    (req_data),
      .req_ready   (req_ready),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .tx_start    (tx_start),
      .tx_data     (tx_data),
      .grant_id    (grant_id),
      .arb_busy    (arb_busy),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      assert (got === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_byte(input int i, input logic [7:0] b);
      req_data[8*i +: 8] = b;
   endtask

   // Called in the LAUNCH cycle: the scoreboard byte must be on tx_data.
   task automatic chk_launch(input int exp_id);
      logic [7:0] e;
      e = 8'hxx;
      chk("tx_start", tx_start, 1);
      chk("grant_id", grant_id, exp_id);
      chk("sb_empty", exp_q.size() == 0, 0);
      if (exp_q.size() > 0) e = exp_q.pop_front();
      chk("tx_data", tx_data, e);
   endtask

   // Models uart_tx: busy after the start pulse, tx_done dly clocks after tx_start.
   task automatic frame(input int dly, input logic [7:0] b);
      tick();
      tx_busy = 1'b1;
      #1;
      chk("start_pulse", tx_start, 0);
      chk("ready_outside_idle", req_ready, 0);
      repeat (dly - 1) tick();
      chk("tx_data_hold", tx_data, b);
      tx_done = 1'b1;
      tx_busy = 1'b0;
      tick();
      tx_done = 1'b0;
      #1;
      chk("idle_after_done", arb_busy, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1, "watchdog");
   end

   initial begin
      int seen;
      seen      = 0;
      sw_reset  = 1'b1;
      req_valid = '0;
      req_data  = '0;
      tx_busy   = 1'b0;
      tx_done   = 1'b0;
      #3;
      chk("rst_ready", req_ready, 0);
      chk("rst_start", tx_start, 0);
      chk("rst_data", tx_data, 0);
      chk("rst_gid", grant_id, 0);
      chk("rst_busy", arb_busy, 0);
      chk("rst_err", err_timeout, 0);
      req_valid = 4'hF;
      req_data  = 32'h13121110;
      #1;
      chk("rst_ready_gated", req_ready, 0);

      // all four requesters continuously valid
      exp_q.push_back(8'h10);
      exp_q.push_back(8'h11);
      exp_q.push_back(8'h12);
      exp_q.push_back(8'h13);
      exp_q.push_back(8'h10);
      tick();
      sw_reset = 1'b0;
      #1;
      for (int k = 0; k < 5; k++) begin
         chk("rr_ready", req_ready, 4'b1 << (k % 4));
         tick();
         if (k == 4) req_valid = '0;
         #1;
         chk_launch(k % 4);
         frame(3, 8'h10 + 8'(k % 4));
      end

      // single requester 2
      set_byte(2, 8'h41);
      req_valid = 4'b0100;
      exp_q.push_back(8'h41);
      #1;
      chk("t1_ready", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      #1;
      chk_launch(2);
      chk("t1_busy", arb_busy, 1);
      frame(10, 8'h41);

      // grant 1, then 0 and 3 together: 3 wins the wrap
      set_byte(1, 8'h21);
      req_valid = 4'b0010;
      exp_q.push_back(8'h21);
      #1;
      chk("t3_ready1", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      #1;
      chk_launch(1);
      frame(4, 8'h21);
      set_byte(0, 8'h30);
      set_byte(3, 8'h33);
      req_valid = 4'b1001;
      exp_q.push_back(8'h33);
      exp_q.push_back(8'h30);
      #1;
      chk("t3_wrap", req_ready, 4'b1000);
      tick();
      req_valid = 4'b0001;
      #1;
      chk_launch(3);
      frame(4, 8'h33);
      chk("t3_next", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      #1;
      chk_launch(0);
      frame(4, 8'h30);

      // tx_busy stalls LAUNCH, then a hung transmitter times out
      tx_busy = 1'b1;
      set_byte(1, 8'h55);
      req_valid = 4'b0010;
      exp_q.push_back(8'h55);
      #1;
      chk("t4_ready", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      #1;
      for (int i = 0; i < 50; i++) begin
         if (tx_start) seen++;
         tick();
      end
      chk("t4_no_start", seen, 0);
      chk("t4_stall_busy", arb_busy, 1);
      chk("t4_stall_err", err_timeout, 0);
      tx_busy = 1'b0;
      #1;
      chk_launch(1);
      tick();
      repeat (T - 1) tick();
      #1;
      chk("t4_last_wait", arb_busy, 1);
      chk("t4_err_early", err_timeout, 0);
      tick();
      #1;
      chk("t4_err", err_timeout, 1);
      chk("t4_idle", arb_busy, 0);
      set_byte(2, 8'h66);
      req_valid = 4'b0100;
      exp_q.push_back(8'h66);
      #1;
      chk("t4_ready_after", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      #1;
      chk_launch(2);
      frame(2, 8'h66);
      chk("t4_err_sticky", err_timeout, 1);

      // async reset in WAIT_DONE
      set_byte(0, 8'h77);
      req_valid = 4'b0001;
      exp_q.push_back(8'h77);
      #1;
      chk("t5_ready", req_ready, 4'b0001);
      tick();
      req_valid = '0;
      #1;
      chk_launch(0);
      tick();
      tx_busy = 1'b1;
      tick();
      tick();
      req_valid = 4'b0011;
      sw_reset  = 1'b1;
      #1;
      chk("t5_start", tx_start, 0);
      chk("t5_data", tx_data, 0);
      chk("t5_gid", grant_id, 0);
      chk("t5_busy", arb_busy, 0);
      chk("t5_err", err_timeout, 0);
      chk("t5_ready_gated", req_ready, 0);
      tick();
      sw_reset = 1'b0;
      tx_busy  = 1'b0;
      set_byte(0, 8'h80);
      set_byte(1, 8'h81);
      exp_q.push_back(8'h80);
      exp_q.push_back(8'h81);
      #1;
      chk("t5_prio0", req_ready, 4'b0001);
      tick();
      req_valid = 4'b0010;
      #1;
      chk_launch(0);
      frame(3, 8'h80);
      chk("t5_next", req_ready, 4'b0010);
      tick();
      req_valid = '0;
      #1;
      chk_launch(1);
      frame(3, 8'h81);

      // tx_done on the final timeout cycle counts as done
      set_byte(2, 8'h99);
      req_valid = 4'b0100;
      exp_q.push_back(8'h99);
      #1;
      chk("t6_ready", req_ready, 4'b0100);
      tick();
      req_valid = '0;
      #1;
      chk_launch(2);
      tick();
      tx_busy = 1'b1;
      repeat (T - 1) tick();
      tx_done = 1'b1;
      tx_busy = 1'b0;
      tick();
      tx_done = 1'b0;
      #1;
      chk("t6_idle", arb_busy, 0);
      chk("t6_err", err_timeout, 0);
      chk("sb_drained", exp_q.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
